// File: rtl/apu_frame_seq_if.sv
// CPU register port into the APU frame sequencer: one-cycle strobe, address,
// direction, write data and combinational read data.
interface apu_frame_seq_if;
  logic        i_reg_cs;
  logic [15:0] i_reg_addr;
  logic        i_reg_wn;
  logic [7:0]  i_reg_wdata;
  logic [7:0]  o_reg_rdata;

  modport master (
    output i_reg_cs, i_reg_addr, i_reg_wn, i_reg_wdata,
    input  o_reg_rdata
  );

  modport slave (
    input  i_reg_cs, i_reg_addr, i_reg_wn, i_reg_wdata,
    output o_reg_rdata
  );
endinterface

// File: rtl/apu_frame_seq.sv
// 2A03 APU frame sequencer: $4017 frame counter, $4015 enable/status, frame IRQ
// and per-channel length counters feeding the channel generators.
module apu_frame_seq #(
  parameter int STEP_CYC = 7457,
  parameter int CNT_W    = 13,
  parameter int NCH      = 4,
  parameter int TRI_CH   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  apu_frame_seq_if.slave   bus,
  input  logic             i_dmc_irq,
  input  logic             i_dmc_active,
  output logic             o_dmc_en,
  output logic             o_qtr_frame,
  output logic             o_half_frame,
  output logic [NCH-1:0]   o_len_active,
  output logic             o_irq_n
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYC - 1);

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    v = 8'd0;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   5'd31: v = 8'd30;
    endcase
    return v;
  endfunction

  logic             wr, rd_sta, wr_frm, wr_sta, ch_hit;
  logic [1:0]       ch_sel, ch_reg;
  logic [7:0]       wdata;
  logic [NCH-1:0]   ch_wr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic             mode_q, inhibit_q, frm_irq_q, step_evt;
  logic             qtr_d, half_d, irq_set, qtr_p1, half_p1;
  logic [NCH-1:0]   en_q, halt_q;
  logic [7:0]       len_q [NCH];
  logic             dmc_en_q;
  logic [3:0]       la4;

  assign wdata    = bus.i_reg_wdata;
  assign wr       = bus.i_reg_cs & ~bus.i_reg_wn;
  assign wr_frm   = wr & (bus.i_reg_addr == 16'h4017);
  assign wr_sta   = wr & (bus.i_reg_addr == 16'h4015);
  assign rd_sta   = bus.i_reg_cs & bus.i_reg_wn & (bus.i_reg_addr == 16'h4015);
  assign ch_hit   = (bus.i_reg_addr[15:4] == 12'h400);
  assign ch_sel   = bus.i_reg_addr[3:2];
  assign ch_reg   = bus.i_reg_addr[1:0];
  assign step_evt = (cnt_q == CNT_LAST);

  always_comb begin
    for (int c = 0; c < NCH; c++) ch_wr[c] = wr & ch_hit & (ch_sel == 2'(c));
  end

  // Sequencer state register and registered Q/H pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      step_q    <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      frm_irq_q <= 1'b0;
      qtr_p1    <= 1'b0;
      half_p1   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      qtr_p1  <= qtr_d;
      half_p1 <= half_d;
      if (wr_frm) begin
        mode_q    <= wdata[7];
        inhibit_q <= wdata[6];
      end
      // An IRQ set beats a coincident status read; the read returns the old value
      if (wr_frm && wdata[6]) frm_irq_q <= 1'b0;
      else if (irq_set)       frm_irq_q <= 1'b1;
      else if (rd_sta)        frm_irq_q <= 1'b0;
    end
  end

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    step_d = step_q;
    if (wr_frm) begin
      cnt_d  = '0;
      step_d = '0;
    end else if (step_evt) begin
      cnt_d = '0;
      if ((step_q == 3'd3 && !mode_q) || step_q == 3'd4) step_d = '0;
      else                                                step_d = step_q + 3'd1;
    end
  end

  // A $4017 write overrides any step event landing in the same cycle
  always_comb begin
    qtr_d   = 1'b0;
    half_d  = 1'b0;
    irq_set = 1'b0;
    if (wr_frm) begin
      qtr_d  = wdata[7];
      half_d = wdata[7];
    end else if (step_evt) begin
      case (step_q)
        3'd1: begin qtr_d = 1'b1; half_d = 1'b1; end
        3'd3: if (!mode_q) begin
          qtr_d   = 1'b1;
          half_d  = 1'b1;
          irq_set = ~inhibit_q;
        end
        3'd4: begin qtr_d = 1'b1; half_d = 1'b1; end
        default: qtr_d = 1'b1;
      endcase
    end
  end

  // Channel enables, halt flags and length counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q     <= '0;
      halt_q   <= '0;
      dmc_en_q <= 1'b0;
      for (int c = 0; c < NCH; c++) len_q[c] <= '0;
    end else begin
      if (wr_sta) begin
        en_q     <= wdata[NCH-1:0];
        dmc_en_q <= wdata[4];
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_wr[c] && ch_reg == 2'd0) halt_q[c] <= (c == TRI_CH) ? wdata[7] : wdata[5];
        if (!en_q[c] || (wr_sta && !wdata[c]))
          len_q[c] <= '0;
        else if (ch_wr[c] && ch_reg == 2'd3)
          len_q[c] <= len_lut(wdata[7:3]);
        else if (half_p1 && len_q[c] != 8'd0 && !halt_q[c])
          len_q[c] <= len_q[c] - 1'b1;
      end
    end
  end

  always_comb begin
    la4 = '0;
    for (int c = 0; c < NCH; c++) begin
      o_len_active[c] = (len_q[c] != 8'd0);
      la4[c]          = (len_q[c] != 8'd0);
    end
  end

  assign bus.o_reg_rdata = rd_sta ? {i_dmc_irq, frm_irq_q, 1'b0, i_dmc_active, la4} : 8'h00;
  assign o_irq_n         = ~(frm_irq_q | i_dmc_irq);
  assign o_qtr_frame     = qtr_p1;
  assign o_half_frame    = half_p1;
  assign o_dmc_en        = dmc_en_q;
endmodule

// File: tb/tb_apu_frame_seq.sv
// Scoreboard bench for apu_frame_seq: a cycle-count reference model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_apu_frame_seq;
  localparam int S    = 8;
  localparam int NCH  = 4;
  localparam int TRI  = 2;
  localparam int LUT [32] = '{10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,
                              12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, dmc_irq, dmc_active, dmc_en, qtr, half, irq_n;
  logic [NCH-1:0] la;
  apu_frame_seq_if bus();

  apu_frame_seq #(.STEP_CYC(S), .CNT_W(4), .NCH(NCH), .TRI_CH(TRI)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .i_dmc_irq(dmc_irq),
    .i_dmc_active(dmc_active), .o_dmc_en(dmc_en), .o_qtr_frame(qtr),
    .o_half_frame(half), .o_len_active(la), .o_irq_n(irq_n)
  );

  typedef struct packed {
    logic q; logic h; logic [NCH-1:0] la; logic irqn; logic dmcen; logic [7:0] rd;
  } exp_t;
  exp_t sbq[$];
  int errs = 0, checks = 0;

  // Reference model: t counts cycles since the sequence was (re)started
  int   t;
  bit   mode, inh, firq, mq, mh, mdmc, mvalid = 1'b0;
  int   len [NCH];
  bit   en [NCH], halt [NCH];
  logic [7:0] last_rd;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %02h, want %02h", name, $time, act, exp);
    end
  endtask

  task automatic model_adv(input bit r, input bit cs, input logic [15:0] a,
                           input bit wn, input logic [7:0] d);
    bit wr, frm_w, sta_w, sta_r, nq, nh, set, chw;
    int k, off;
    if (r) begin
      t = 0; mode = 0; inh = 0; firq = 0; mq = 0; mh = 0; mdmc = 0; mvalid = 1;
      for (int c = 0; c < NCH; c++) begin len[c] = 0; en[c] = 0; halt[c] = 0; end
      return;
    end
    wr = cs && !wn;
    frm_w = wr && a == 16'h4017;
    sta_w = wr && a == 16'h4015;
    sta_r = cs && wn && a == 16'h4015;
    off = int'(a) - 'h4000;
    nq = 0; nh = 0; set = 0;
    for (int c = 0; c < NCH; c++) begin
      chw = wr && off >= 0 && off < 16 && off / 4 == c;
      if (sta_w) en[c] = d[c];
      if (!en[c]) len[c] = 0;
      else if (chw && off % 4 == 3) len[c] = LUT[d[7:3]];
      else if (mh && len[c] > 0 && !halt[c]) len[c]--;
      if (chw && off % 4 == 0) halt[c] = (c == TRI) ? d[7] : d[5];
    end
    if (sta_w) mdmc = d[4];
    if (frm_w) begin
      mode = d[7]; inh = d[6];
      if (d[6]) firq = 0;
      t = 0; nq = d[7]; nh = d[7];
    end else begin
      if (t % S == S - 1) begin
        k = (t / S) % (mode ? 5 : 4);
        if (!mode) begin nq = 1; nh = (k == 1 || k == 3); set = (k == 3) && !inh; end
        else begin nq = (k != 3); nh = (k == 1 || k == 4); end
      end
      t++;
      if (set) firq = 1;
      else if (sta_r) firq = 0;
    end
    mq = nq; mh = nh;
  endtask

  // One clock cycle: drive, predict, advance model, cross the edge
  task automatic cyc(input bit r, input bit cs, input logic [15:0] a,
                     input bit wn, input logic [7:0] d);
    exp_t e;
    rst = r; bus.i_reg_cs = cs; bus.i_reg_addr = a; bus.i_reg_wn = wn; bus.i_reg_wdata = d;
    if (mvalid) begin
      e.q = mq; e.h = mh; e.irqn = !(firq || dmc_irq); e.dmcen = mdmc;
      e.rd = {dmc_irq, firq, 1'b0, dmc_active, 4'b0};
      for (int c = 0; c < NCH; c++) begin
        e.la[c] = (len[c] != 0);
        if (len[c] != 0) e.rd[c] = 1'b1;
      end
      if (!(cs && wn && a == 16'h4015)) e.rd = 8'h00;
      sbq.push_back(e);
    end
    model_adv(r, cs, a, wn, d);
    #2 last_rd = bus.o_reg_rdata;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 16'h0000, 0, 8'h00);
  endtask
  task automatic wreg(input logic [15:0] a, input logic [7:0] d);
    cyc(0, 1, a, 0, d);
  endtask
  task automatic rreg(input logic [15:0] a);
    cyc(0, 1, a, 1, 8'h00);
  endtask
  task automatic wait_step4();
    int n = 0;
    while (!(t == 4 * S - 1 && !mode) && n < 200) begin idle(1); n++; end
    if (n >= 200) chk("wait_step4_bound", 8'h01, 8'h00);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("qtr_frame",  {7'b0, qtr},    {7'b0, e.q});
      chk("half_frame", {7'b0, half},   {7'b0, e.h});
      chk("len_active", {4'b0, la},     {4'b0, e.la});
      chk("irq_n",      {7'b0, irq_n},  {7'b0, e.irqn});
      chk("dmc_en",     {7'b0, dmc_en}, {7'b0, e.dmcen});
      chk("reg_rdata",  bus.o_reg_rdata, e.rd);
    end
  end

  initial begin
    int n;
    rst = 1; dmc_irq = 0; dmc_active = 0;
    bus.i_reg_cs = 0; bus.i_reg_addr = 0; bus.i_reg_wn = 0; bus.i_reg_wdata = 0;
    #1;
    cyc(1, 0, 16'h0000, 0, 8'h00);
    cyc(1, 0, 16'h0000, 0, 8'h00);

    // 4-step sequence and IRQ read/clear
    idle(40);
    chk("irq_n_after_4step", {7'b0, irq_n}, 8'h00);
    rreg(16'h4015); chk("rd4015_irq", last_rd, 8'h40);
    rreg(16'h4015); chk("rd4015_cleared", last_rd, 8'h00);

    // 5-step mode
    wreg(16'h4017, 8'h80);
    idle(50);
    rreg(16'h4015); chk("5step_no_irq", last_rd & 8'h40, 8'h00);

    // Inhibit
    wreg(16'h4017, 8'h00); idle(34);
    chk("irq_before_inhibit", {7'b0, irq_n}, 8'h00);
    wreg(16'h4017, 8'h40);
    chk("inhibit_clears", {7'b0, irq_n}, 8'h01);
    idle(96);
    chk("inhibit_holds", {7'b0, irq_n}, 8'h01);
    rreg(16'h4015); chk("inhibit_status", last_rd, 8'h00);
    wreg(16'h4017, 8'h00);

    // Length counter run-down
    wreg(16'h4015, 8'h01); wreg(16'h4003, 8'h08);
    chk("len_loaded", {4'b0, la}, 8'h01);
    idle(254 * 2 * S + 40);
    rreg(16'h4015); chk("len_expired", last_rd & 8'h0F, 8'h00);

    // Halt, then disable
    wreg(16'h4000, 8'h20); wreg(16'h4003, 8'h08);
    idle(70);
    chk("halt_holds", {4'b0, la}, 8'h01);
    wreg(16'h4015, 8'h00);
    chk("disable_clears", {4'b0, la}, 8'h00);
    wreg(16'h4003, 8'h08);
    chk("load_ignored", {4'b0, la}, 8'h00);
    wreg(16'h4000, 8'h00);

    // Collision: $4017 write on the step-4 event
    wreg(16'h4017, 8'h40); wreg(16'h4017, 8'h00);
    wait_step4();
    wreg(16'h4017, 8'h00);
    idle(20);
    chk("frm_write_kills_irq", {7'b0, irq_n}, 8'h01);

    // Collision: load on an H pulse (LUT[3] = 2)
    wreg(16'h4015, 8'h02);
    n = 0;
    while (!mh && n < 200) begin idle(1); n++; end
    if (n >= 200) chk("wait_h_bound", 8'h01, 8'h00);
    wreg(16'h4007, 8'h18);
    idle(2 * 2 * S + 4);

    // Collision: status read on the IRQ set
    wreg(16'h4017, 8'h40); wreg(16'h4017, 8'h00);
    wait_step4();
    rreg(16'h4015);
    rreg(16'h4015); chk("read_vs_set", last_rd & 8'h40, 8'h40);

    // Randomized traffic
    repeat (4000) begin
      logic [15:0] a;
      int pick;
      dmc_irq    = ($urandom_range(0, 7) == 0);
      dmc_active = $urandom_range(0, 1);
      pick = $urandom_range(0, 19);
      if (pick < 16)       a = 16'h4000 + 16'(pick);
      else if (pick < 18)  a = 16'h4015;
      else if (pick == 18) a = ($urandom_range(0, 3) == 0) ? 16'h4017 : 16'h4015;
      else                 a = 16'($urandom);
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0, a,
          $urandom_range(0, 1), 8'($urandom));
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 8'(sbq.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
